// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_gen_pkg: shared 800x600@60 raster timing and pixel type for the VGA input and output paths
package vga_timing_gen_pkg;
  localparam int WIDTH = 800;
  localparam int FRONT_H = 40;
  localparam int PULSE_H = 128;
  localparam int BACK_H = 88;
  localparam int HEIGHT = 600;
  localparam int FRONT_V = 1;
  localparam int PULSE_V = 4;
  localparam int BACK_V = 23;
  localparam int H_TOTAL = PULSE_H + BACK_H + WIDTH + FRONT_H;
  localparam int V_TOTAL = PULSE_V + BACK_V + HEIGHT + FRONT_V;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel request/data handshake plus registered video outputs
interface vga_timing_gen_if;
  import vga_timing_gen_pkg::*;
  logic pixel_request;
  logic [10:0] i;
  logic [10:0] j;
  logic frame_start;
  pixel_t pixel_data;
  logic hsync;
  logic vsync;
  logic de;
  pixel_t rgb;
  modport master (output pixel_request, i, j, frame_start, hsync, vsync, de, rgb, input pixel_data);
  modport slave (input pixel_request, i, j, frame_start, hsync, vsync, de, rgb, output pixel_data);
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis laid out as sync pulse, back porch, active, front porch
module vga_axis_counter #(
  parameter int PULSE = 128,
  parameter int BACK = 88,
  parameter int ACTIVE = 800,
  parameter int FRONT = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic [10:0] cnt,
  output logic active,
  output logic sync,
  output logic [10:0] idx
);
  localparam logic [10:0] START_C = 11'(PULSE + BACK);
  localparam logic [10:0] END_C = 11'(PULSE + BACK + ACTIVE);
  localparam logic [10:0] LAST_C = 11'(PULSE + BACK + ACTIVE + FRONT - 1);
  localparam logic [10:0] PULSE_C = 11'(PULSE);
  // step on enable and fold back to zero after the last front-porch position
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (en) cnt <= cnt == LAST_C ? '0 : cnt + 11'd1;
  // decode region flags and the offset into the active window
  always_comb begin
    active = cnt >= START_C && cnt < END_C;
    sync = cnt < PULSE_C;
    idx = cnt - START_C;
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster generator issuing pixel requests one cycle ahead of aligned syncs, DE and RGB
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int width = WIDTH,
  parameter int front_h = FRONT_H,
  parameter int pulse_h = PULSE_H,
  parameter int back_h = BACK_H,
  parameter int height = HEIGHT,
  parameter int front_v = FRONT_V,
  parameter int pulse_v = PULSE_V,
  parameter int back_v = BACK_V,
  parameter logic hsync_active = 1'b1,
  parameter logic vsync_active = 1'b1
) (
  input logic clk,
  input logic rst,
  vga_timing_gen_if.master vid
);
  localparam logic [10:0] H_LAST = 11'(pulse_h + back_h + width + front_h - 1);
  logic [10:0] h_cnt, v_cnt, h_idx, v_idx;
  logic h_act, v_act, h_sync, v_sync, h_wrap;
  assign h_wrap = h_cnt == H_LAST;
  vga_axis_counter #(.PULSE(pulse_h), .BACK(back_h), .ACTIVE(width), .FRONT(front_h)) u_h (
    .clk(clk), .rst(rst), .en(1'b1), .cnt(h_cnt), .active(h_act), .sync(h_sync), .idx(h_idx)
  );
  vga_axis_counter #(.PULSE(pulse_v), .BACK(back_v), .ACTIVE(height), .FRONT(front_v)) u_v (
    .clk(clk), .rst(rst), .en(h_wrap), .cnt(v_cnt), .active(v_act), .sync(v_sync), .idx(v_idx)
  );
  // request stage is pure decode of the counters
  always_comb begin
    vid.pixel_request = h_act & v_act;
    vid.i = v_idx;
    vid.j = h_idx;
    vid.frame_start = h_cnt == '0 && v_cnt == '0;
  end
  // delay syncs and DE by one cycle so they line up with the returned pixel
  always_ff @(posedge clk)
    if (rst) begin
      vid.hsync <= ~hsync_active;
      vid.vsync <= ~vsync_active;
      vid.de <= 1'b0;
    end else begin
      vid.hsync <= h_sync ? hsync_active : ~hsync_active;
      vid.vsync <= v_sync ? vsync_active : ~vsync_active;
      vid.de <= vid.pixel_request;
    end
  // upstream returns data in the DE cycle; blank it everywhere else
  always_comb vid.rgb = vid.de ? vid.pixel_data : '0;
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Transmit-side counterpart of the VGA input indexer. Generates HSync, VSync and DE for the DVI/VGA output path from free-running raster counters.
- Issues a per-pixel request carrying the (i, j) coordinate one cycle ahead of the video output.
- Registers the returned pixel data so that video, syncs and DE leave the block cycle-aligned.
- Line and frame order matches the input side: sync pulse, back porch, active, front porch.

Parameters:
- Width, 800, active pixels per line
- FrontH, 40, horizontal front porch (clocks)
- PulseH, 128, HSync pulse width (clocks)
- BackH, 88, horizontal back porch (clocks)
- Height, 600, active lines per frame
- FrontV, 1, vertical front porch (lines)
- PulseV, 4, VSync pulse width (lines)
- BackV, 23, vertical back porch (lines)
- HSyncActive, 1, asserted level of HSync
- VSyncActive, 1, asserted level of VSync

Ports:
- Clock  in  1  pixel clock; single clock domain
- Reset  in  1  synchronous, active-high reset
- PixelRequest  out  1  coordinate (i, j) is active; PixelData must be supplied the next cycle
- i  out  11  active line index, 0..Height-1; meaningful only while PixelRequest=1
- j  out  11  active column index, 0..Width-1; meaningful only while PixelRequest=1
- FrameStart  out  1  one-cycle pulse at raster origin (h=0, v=0), request stage
- PixelData  in  24  {R,G,B}, sampled one cycle after PixelRequest
- HSync  out  1  horizontal sync, output stage
- VSync  out  1  vertical sync, output stage
- DE  out  1  data enable, output stage
- RGB  out  24  video data, output stage; 0 when DE=0

Behaviour:
- Totals: HTotal = PulseH+BackH+Width+FrontH (1056); VTotal = PulseV+BackV+Height+FrontV (628).
- Counters h and v are 11 bits, unsigned.
- Counter stage:
  - h increments each cycle.
  - At h=HTotal-1: h->0 and v increments.
  - At h=HTotal-1 with v=VTotal-1: h->0 and v->0.
  - No other wrap point; h and v never exceed HTotal-1 and VTotal-1.
- Request stage (combinational from the counters):
  - hAct = PulseH+BackH <= h < PulseH+BackH+Width.
  - vAct = PulseV+BackV <= v < PulseV+BackV+Height.
  - PixelRequest = hAct & vAct.
  - j = h-(PulseH+BackH); i = v-(PulseV+BackV). Both are truncated to 11 bits.
  - FrameStart = (h==0)&(v==0).
- Output stage, registered, 1-cycle latency from the request stage:
  - HSync = HSyncActive when h<PulseH, else ~HSyncActive.
  - VSync = VSyncActive when v<PulseV, else ~VSyncActive. VSync changes only at line start (h=0).
  - DE = registered PixelRequest.
  - RGB = PixelData when the registered PixelRequest=1, else 24'h0.
- Upstream contract: fixed latency of 1, no backpressure. The block never stalls, and PixelData is ignored outside request+1 cycles.
- Reset:
  - h=0, v=0.
  - HSync=~HSyncActive, VSync=~VSyncActive, DE=0, RGB=0.
  - Reset mid-frame aborts the frame immediately. The output stage is blanked in the same cycle the reset is sampled.
- First cycle after Reset deasserts: counters at (0,0), FrameStart=1. HSync and VSync assert at the output one cycle later.
- Per frame: exactly Width*Height requests and Width*Height DE cycles. DE is high for exactly Width consecutive cycles per active line.
- Boundary: the last active pixel (i=Height-1, j=Width-1) is followed by FrontH blanking, then the sync of the next line. No request spans the line wrap.

Decomposition:
- Shared package holds:
  - the 800x600@60 timing constants (Width, FrontH, PulseH, BackH, Height, FrontV, PulseV, BackV and totals), so this block and the input indexer use one source;
  - the 24-bit pixel type {R,G,B}.
- One natural sub-module, vga_axis_counter: a parameterised pulse/back/active/front counter with wrap, active flag, sync flag and offset index. It is instantiated twice (horizontal, and vertical advanced by the horizontal wrap).

Test Plan:
- Reset held 5 cycles, then released -> FrameStart=1 on the first cycle; HSync=VSync=1 next cycle; DE=0, RGB=0 throughout reset.
- Run 2 full frames -> HSync period 1056 clocks, high 128; VSync high 4*1056 clocks, period 628*1056=663168 clocks; FrameStart period 663168.
- Drive PixelData={i[7:0], j[7:0], 8'hA5} from the sampled request -> RGB equals the expected value exactly 1 cycle after each request.
- Count per frame -> 480000 requests and 480000 DE cycles. First request at h=216, v=27 with i=0, j=0. Last request at i=599, j=799.
- Drive PixelData=24'hFFFFFF constantly -> RGB=0 whenever DE=0, including the porches and sync regions.
- Assert Reset for 1 cycle mid-active (i=300, j=400) -> the next cycle has DE=0 and RGB=0. The raster restarts with FrameStart on the cycle after Reset deasserts.
